// File: rtl/counter_down_seq_if.sv
// Handshake bundle for counter_down_seq: controller-side commands and
// counter-side status. The controller uses the master view, the counter
// uses the slave view.
interface counter_down_seq_if #(
   parameter int W = 4
) ();
   logic         load;
   logic [W-1:0] d;
   logic         start;
   logic         enable;
   logic         abort;
   logic         busy;
   logic         done;
   logic         max_tick;
   logic         min_tick;
   logic [W-1:0] q;

   modport master (
      output load, d, start, enable, abort,
      input  busy, done, max_tick, min_tick, q
   );

   modport slave (
      input  load, d, start, enable, abort,
      output busy, done, max_tick, min_tick, q
   );
endinterface

// File: rtl/counter_down_seq.sv
// Loadable down-counter sequencer with start/done handshake.
// IDLE accepts load/start, RUN decrements on enable until the 1->0 step,
// DONE is a single-cycle completion state.
// Optional macro COUNTER_DOWN_AUTO_RELOAD_EN turns RUN into a periodic
// tick generator: the 1->0 step reloads the preset and stays in RUN.
module counter_down_seq #(
   parameter int W = 4
) (
   input logic              clk,
   input logic              rst,
   counter_down_seq_if.slave bus
);
   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   localparam logic [W-1:0] ONE = W'(1);
   localparam logic [W-1:0] MAX = {W{1'b1}};

   state_t       state_q, state_d;
   logic [W-1:0] q_q, q_d;
   logic [W-1:0] rl_q, rl_d;
   logic         done_q, done_d;

   logic [W-1:0] eff_cnt;
   logic         dec_fire;
   logic         last_step;

   // Count used to decide where a start goes: a same-cycle load wins over q
   assign eff_cnt   = bus.load ? bus.d : q_q;
   assign dec_fire  = bus.enable && !bus.abort;
   assign last_step = dec_fire && (q_q == ONE);

   // State, count, reload and done registers with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= S_IDLE;
         q_q     <= '0;
         rl_q    <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         q_q     <= q_d;
         rl_q    <= rl_d;
         done_q  <= done_d;
      end
   end

   // Next-state decision; abort has priority over the final decrement
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (bus.start) begin
               state_d = (eff_cnt != '0) ? S_RUN : S_DONE;
            end
         end
         S_RUN: begin
            if (bus.abort) begin
               state_d = S_IDLE;
`ifndef COUNTER_DOWN_AUTO_RELOAD_EN
            end else if (last_step) begin
               state_d = S_DONE;
`endif
            end
         end
         S_DONE: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Count/reload update and the registered completion flag
   always_comb begin
      q_d    = q_q;
      rl_d   = rl_q;
      done_d = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (bus.load) begin
               q_d  = bus.d;
               rl_d = bus.d;
            end
            if (bus.start && (eff_cnt == '0)) begin
               done_d = 1'b1;
            end
         end
         S_RUN: begin
            if (last_step) begin
`ifdef COUNTER_DOWN_AUTO_RELOAD_EN
               q_d = rl_q;
`else
               q_d = '0;
`endif
               done_d = 1'b1;
            end else if (dec_fire && (q_q != '0)) begin
               q_d = q_q - ONE;
            end
         end
         S_DONE: q_d = '0;
         default: q_d = q_q;
      endcase
   end

   // Status outputs: busy from state, ticks are pure decodes of q
   always_comb begin
      bus.busy     = (state_q == S_RUN);
      bus.done     = done_q;
      bus.q        = q_q;
      bus.max_tick = (q_q == MAX);
      bus.min_tick = (q_q == '0);
   end
endmodule

// File: tb/tb_counter_down_seq.sv
// Self-checking bench for counter_down_seq: directed scenarios followed by
// randomized traffic, every cycle compared against a behavioural model.
module tb_counter_down_seq;
   localparam int W   = 4;
   localparam int MAXV = (1 << W) - 1;

   logic clk;
   logic rst;
   int   n_chk;
   int   n_err;

   counter_down_seq_if #(.W(W)) bus ();

   counter_down_seq #(.W(W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural model: mode 0=idle, 1=run, 2=done
   int m_mode;
   int m_q;
   int m_rl;
   int m_done;

   task automatic chk(input string tag, input int obs, input int exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_step();
      int eff;
      if (!rst) begin
         m_mode = 0; m_q = 0; m_rl = 0; m_done = 0;
      end else if (m_mode == 0) begin
         m_done = 0;
         eff = bus.load ? int'(bus.d) : m_q;
         if (bus.load) begin
            m_q  = int'(bus.d);
            m_rl = int'(bus.d);
         end
         if (bus.start) begin
            if (eff != 0) m_mode = 1;
            else begin m_mode = 2; m_done = 1; end
         end
      end else if (m_mode == 1) begin
         m_done = 0;
         if (bus.abort) m_mode = 0;
         else if (bus.enable) begin
            if (m_q == 1) begin
               m_done = 1;
`ifdef COUNTER_DOWN_AUTO_RELOAD_EN
               m_q = m_rl;
`else
               m_q = 0;
               m_mode = 2;
`endif
            end else if (m_q > 1) m_q = m_q - 1;
         end
      end else begin
         m_mode = 0; m_done = 0; m_q = 0;
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
      chk("q", int'(bus.q), m_q);
      chk("busy", int'(bus.busy), (m_mode == 1) ? 1 : 0);
      chk("done", int'(bus.done), m_done);
      chk("max_tick", int'(bus.max_tick), (m_q == MAXV) ? 1 : 0);
      chk("min_tick", int'(bus.min_tick), (m_q == 0) ? 1 : 0);
   endtask

   task automatic idle_inputs();
      bus.load = 1'b0; bus.d = '0; bus.start = 1'b0;
      bus.enable = 1'b0; bus.abort = 1'b0;
   endtask

   initial begin
      n_chk = 0; n_err = 0;
      m_mode = 0; m_q = 0; m_rl = 0; m_done = 0;
      rst = 1'b0;
      idle_inputs();

      // 1: reset overrides load/start
      bus.load = 1'b1; bus.d = 4'd9; bus.start = 1'b1;
      repeat (2) tick();
      chk("rst_q", int'(bus.q), 0);
      chk("rst_busy", int'(bus.busy), 0);
      chk("rst_done", int'(bus.done), 0);
      chk("rst_min", int'(bus.min_tick), 1);
      chk("rst_max", int'(bus.max_tick), 0);
      idle_inputs();
      rst = 1'b1;
      tick();
      chk("rel_q", int'(bus.q), 0);

      // 2: single shot of 3
      bus.load = 1'b1; bus.d = 4'd3;
      tick();
      bus.load = 1'b0; bus.start = 1'b1; bus.enable = 1'b1;
      tick();
      chk("ss_busy0", int'(bus.busy), 1);
      chk("ss_q0", int'(bus.q), 3);
      bus.start = 1'b0;
      tick();
      chk("ss_q1", int'(bus.q), 2);
      tick();
      chk("ss_q2", int'(bus.q), 1);
      tick();
`ifndef COUNTER_DOWN_AUTO_RELOAD_EN
      chk("ss_done", int'(bus.done), 1);
      chk("ss_qend", int'(bus.q), 0);
      chk("ss_busyend", int'(bus.busy), 0);
      tick();
      chk("ss_done_off", int'(bus.done), 0);
`else
      bus.abort = 1'b1;
      tick();
`endif
      idle_inputs();
      tick();

      // 3: enable gaps with ignored load/start in RUN
      bus.load = 1'b1; bus.d = 4'd5;
      tick();
      bus.load = 1'b0; bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      for (int i = 0; i < 9; i++) begin
         bus.enable = ((i % 2) == 0);
         bus.load   = (i == 1);
         bus.start  = (i == 1);
         bus.d      = 4'd15;
         tick();
         if (i == 1) chk("gap_q_ign", int'(bus.q), 4);
`ifndef COUNTER_DOWN_AUTO_RELOAD_EN
         if (i == 8) chk("gap_done", int'(bus.done), 1);
         if (i == 6) chk("gap_nodone", int'(bus.done), 0);
`endif
      end
      idle_inputs();
      bus.abort = 1'b1;
      tick();
      idle_inputs();
      tick();

      // 4: abort keeps q, then zero-count start
      bus.load = 1'b1; bus.d = 4'd8;
      tick();
      bus.load = 1'b0; bus.start = 1'b1; bus.enable = 1'b1;
      tick();
      bus.start = 1'b0;
      repeat (3) tick();
      chk("ab_q5", int'(bus.q), 5);
      bus.abort = 1'b1;
      tick();
      chk("ab_busy", int'(bus.busy), 0);
      chk("ab_q", int'(bus.q), 5);
      chk("ab_done", int'(bus.done), 0);
      idle_inputs();
      bus.load = 1'b1; bus.d = 4'd0; bus.start = 1'b1;
      tick();
      chk("z_done", int'(bus.done), 1);
      chk("z_busy", int'(bus.busy), 0);
      idle_inputs();
      tick();
      chk("z_done_off", int'(bus.done), 0);
      chk("z_busy_off", int'(bus.busy), 0);

      // 5: load+start at max value
      bus.load = 1'b1; bus.d = 4'd15; bus.start = 1'b1;
      tick();
      chk("mx_tick", int'(bus.max_tick), 1);
      chk("mx_busy", int'(bus.busy), 1);
      idle_inputs();
      bus.enable = 1'b1;
      tick();
      chk("mx_q14", int'(bus.q), 14);
      chk("mx_tick_off", int'(bus.max_tick), 0);
      idle_inputs();
      bus.abort = 1'b1;
      tick();
      idle_inputs();
      tick();

`ifdef COUNTER_DOWN_AUTO_RELOAD_EN
      // 6: periodic reload of 2
      begin
         int exp_q [7] = '{2, 1, 2, 1, 2, 1, 2};
         bus.load = 1'b1; bus.d = 4'd2;
         tick();
         bus.load = 1'b0; bus.start = 1'b1; bus.enable = 1'b1;
         for (int i = 0; i < 7; i++) begin
            tick();
            bus.start = 1'b0;
            chk("ar_q", int'(bus.q), exp_q[i]);
            chk("ar_busy", int'(bus.busy), 1);
            chk("ar_done", int'(bus.done), (i > 0 && exp_q[i] == 2) ? 1 : 0);
         end
         idle_inputs();
         bus.abort = 1'b1;
         tick();
         chk("ar_ab_busy", int'(bus.busy), 0);
         idle_inputs();
         tick();
         chk("ar_ab_done", int'(bus.done), 0);
      end
`endif

      // Randomized traffic against the model
      for (int i = 0; i < 600; i++) begin
         rst        = ($urandom_range(0, 39) != 0);
         bus.load   = ($urandom_range(0, 3) == 0);
         bus.d      = W'($urandom_range(0, MAXV));
         if ($urandom_range(0, 3) == 0) bus.d = W'($urandom_range(0, 2));
         bus.start  = ($urandom_range(0, 3) == 0);
         bus.enable = ($urandom_range(0, 1) == 0);
         bus.abort  = ($urandom_range(0, 15) == 0);
         tick();
      end

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule
